// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: round count, rcon seed,
// controller FSM encoding and the GF(2^8) xtime helper.
package aes_pkg;

   localparam int         NR        = 10;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: seeded with RCON_INIT on load, multiplied by x in
// GF(2^8) on each step, otherwise held.
module aes_rcon_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       step,
   output logic [7:0] rcon_o
);
   import aes_pkg::*;

   logic [7:0] rcon_q, rcon_d;

   always_comb begin
      rcon_d = rcon_q;
      if (load) begin
         rcon_d = RCON_INIT;
      end else if (step) begin
         rcon_d = xtime(rcon_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcon_q <= RCON_INIT;
      end else begin
         rcon_q <= rcon_d;
      end
   end

   assign rcon_o = rcon_q;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: sequences ten rounds through an
// external round datapath and key-step, one round per clock.
module aes_round_ctrl #(
   parameter int NR        = 10,
   parameter int CLEAR_KEY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start_encryption,
   input  logic [127:0] plaintext_in,
   input  logic [127:0] key_in,
   output logic [127:0] ciphertext_out,
   output logic         encryption_done,
   output logic         busy,
   output logic [127:0] rnd_state_o,
   output logic [127:0] rnd_key_o,
   output logic         rnd_final_o,
   input  logic [127:0] rnd_state_i,
   output logic [127:0] ks_key_o,
   output logic [7:0]   ks_rcon_o,
   input  logic [127:0] ks_key_i
);
   import aes_pkg::*;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] st_q, st_d;
   logic [127:0] key_q, key_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         done_q, done_d;
   logic         rcon_load, rcon_step;
   logic         last_rnd;

   assign last_rnd = (fsm_q == ROUND) && (rnd_q == 4'(NR));

   // Start is only looked at outside ROUND, so DONE can chain straight into a new run.
   always_comb begin
      fsm_d     = fsm_q;
      st_d      = st_q;
      key_d     = key_q;
      ct_d      = ct_q;
      rnd_d     = rnd_q;
      done_d    = 1'b0;
      rcon_load = 1'b0;
      rcon_step = 1'b0;
      case (fsm_q)
         ROUND: begin
            st_d  = rnd_state_i;
            key_d = ks_key_i;
            if (last_rnd) begin
               ct_d   = rnd_state_i;
               done_d = 1'b1;
               fsm_d  = DONE;
               if (CLEAR_KEY != 0) begin
                  key_d = '0;
               end
            end else begin
               rnd_d     = rnd_q + 4'd1;
               rcon_step = 1'b1;
            end
         end
         default: begin
            if (start_encryption) begin
               st_d      = plaintext_in ^ key_in;
               key_d     = key_in;
               rnd_d     = 4'd1;
               rcon_load = 1'b1;
               fsm_d     = ROUND;
            end else begin
               fsm_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= IDLE;
         st_q   <= '0;
         key_q  <= '0;
         ct_q   <= '0;
         rnd_q  <= '0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         key_q  <= key_d;
         ct_q   <= ct_d;
         rnd_q  <= rnd_d;
         done_q <= done_d;
      end
   end

   aes_rcon_gen u_rcon (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (rcon_load),
      .step   (rcon_step),
      .rcon_o (ks_rcon_o)
   );

   assign ciphertext_out  = ct_q;
   assign encryption_done = done_q;
   assign busy            = (fsm_q == ROUND);
   assign rnd_state_o     = st_q;
   assign rnd_key_o       = ks_key_i;
   assign rnd_final_o     = last_rnd;
   assign ks_key_o        = key_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl with behavioural AES round and key-step models
// attached; ciphertexts are checked against the FIPS-197 example vectors.
module tb_aes_round_ctrl;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk, rst_n, start_encryption;
   logic [127:0] plaintext_in, key_in, ciphertext_out;
   logic         encryption_done, busy, rnd_final_o;
   logic [127:0] rnd_state_o, rnd_key_o, rnd_state_i, ks_key_o, ks_key_i;
   logic [7:0]   ks_rcon_o;

   aes_round_ctrl #(.NR(10), .CLEAR_KEY(1)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .start_encryption (start_encryption),
      .plaintext_in     (plaintext_in),
      .key_in           (key_in),
      .ciphertext_out   (ciphertext_out),
      .encryption_done  (encryption_done),
      .busy             (busy),
      .rnd_state_o      (rnd_state_o),
      .rnd_key_o        (rnd_key_o),
      .rnd_final_o      (rnd_final_o),
      .rnd_state_i      (rnd_state_i),
      .ks_key_o         (ks_key_o),
      .ks_rcon_o        (ks_rcon_o),
      .ks_key_i         (ks_key_i)
   );

   // ---------------- golden AES models ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq, r;
      sq = x; r = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                              input logic fin);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      if (!fin) begin
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
      return res ^ rk;
   endfunction

   function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, tmp;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_comb ks_key_i    = key_step(ks_key_o, ks_rcon_o);
   always_comb rnd_state_i = aes_round(rnd_state_o, rnd_key_o, rnd_final_o);

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int           n_checks = 0;
   int           n_errors = 0;
   int           done_cnt = 0;
   logic [127:0] exp_q[$];
   int           exp_cyc_q[$];
   logic [127:0] mon_e;
   int           mon_c;
   logic         rec_en = 1'b0;
   logic [7:0]   rcon_obs[$];
   logic         fin_obs[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && encryption_done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("ciphertext", ciphertext_out, mon_e);
            check("done_cycle", 128'(cyc), 128'(mon_c));
         end
      end
      if (rec_en && busy) begin
         rcon_obs.push_back(ks_rcon_o);
         fin_obs.push_back(rnd_final_o);
      end
   end

   // ---------------- driver tasks ----------------
   // Called right after a falling edge; the following rising edge is the accept edge.
   task automatic start_run(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c);
      start_encryption = 1'b1;
      plaintext_in     = p;
      key_in           = k;
      exp_q.push_back(c);
      exp_cyc_q.push_back(cyc + 11);
      @(negedge clk);
      start_encryption = 1'b0;
   endtask

   task automatic wait_done(input int max_cycles);
      int n;
      n = 0;
      while (n < max_cycles) begin
         @(negedge clk);
         if (encryption_done) break;
         n++;
      end
      if (n >= max_cycles) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done in %0d cycles expected one", max_cycles);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_busy"}, 128'(busy), 128'd0);
      check({tag, "_done"}, 128'(encryption_done), 128'd0);
      check({tag, "_ct"}, ciphertext_out, 128'd0);
      check({tag, "_state"}, rnd_state_o, 128'd0);
      check({tag, "_key"}, ks_key_o, 128'd0);
      check({tag, "_rcon"}, 128'(ks_rcon_o), 128'h01);
      check({tag, "_final"}, 128'(rnd_final_o), 128'd0);
   endtask

   // ---------------- directed sequence ----------------
   logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   int         run1_cyc;

   initial begin
      rst_n = 1'b0; start_encryption = 1'b0; plaintext_in = '0; key_in = '0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // run 1 with an ignored start pulse and input churn at round 5
      rec_en = 1'b1;
      start_run(K1, P1, C1);
      repeat (4) @(negedge clk);
      start_encryption = 1'b1; plaintext_in = P2; key_in = K2;
      @(negedge clk);
      start_encryption = 1'b0;
      plaintext_in = {$urandom, $urandom, $urandom, $urandom};
      key_in       = {$urandom, $urandom, $urandom, $urandom};
      wait_done(20);
      rec_en = 1'b0;
      check("key_cleared", ks_key_o, 128'd0);
      check("rcon_count", 128'(rcon_obs.size()), 128'd10);
      for (int i = 0; i < 10 && i < rcon_obs.size(); i++) begin
         check($sformatf("rcon_r%0d", i + 1), 128'(rcon_obs[i]), 128'(rc_tab[i]));
         check($sformatf("final_r%0d", i + 1), 128'(fin_obs[i]), (i == 9) ? 128'd1 : 128'd0);
      end
      repeat (15) @(negedge clk);
      check("single_done", 128'(done_cnt), 128'd1);
      check("idle_busy", 128'(busy), 128'd0);
      check("idle_rcon_hold", 128'(ks_rcon_o), 128'h36);
      check("idle_state_hold", rnd_state_o, C1);
      check("idle_ct_hold", ciphertext_out, C1);

      // run 1 again, start held from round 8 through DONE -> back-to-back run 2
      start_run(K1, P1, C1);
      run1_cyc = exp_cyc_q[$];
      repeat (7) @(negedge clk);
      start_encryption = 1'b1; plaintext_in = P2; key_in = K2;
      exp_q.push_back(C2);
      exp_cyc_q.push_back(run1_cyc + 11);
      wait_done(20);
      check("b2b_key_cleared", ks_key_o, 128'd0);
      check("b2b_done_busy", 128'(busy), 128'd0);
      @(negedge clk);
      start_encryption = 1'b0;
      check("b2b_restart_busy", 128'(busy), 128'd1);
      wait_done(20);

      // reset asserted at round 7 abandons the run
      @(negedge clk);
      start_run(K2, P2, C2);
      repeat (6) @(negedge clk);
      check("pre_reset_busy", 128'(busy), 128'd1);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("midreset");
      void'(exp_q.pop_back());
      void'(exp_cyc_q.pop_back());
      repeat (3) @(negedge clk);
      check("midreset_no_done", 128'(done_cnt), 128'd3);
      rst_n = 1'b1;
      start_run(K1, P1, C1);
      wait_done(20);
      repeat (3) @(negedge clk);
      check("total_dones", 128'(done_cnt), 128'd4);
      check("queue_empty", 128'(exp_q.size()), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
